// File: rtl/tb_pkg.sv
// Shared definitions for the Needleman-Wunsch traceback walker:
// one-hot RAM symbols, 2-bit step codes and the walker FSM states.
package tb_pkg;
  localparam logic [2:0] SYM_DIAG = 3'b001;
  localparam logic [2:0] SYM_UP   = 3'b010;
  localparam logic [2:0] SYM_LEFT = 3'b100;

  localparam logic [1:0] DIR_DIAG = 2'b01;
  localparam logic [1:0] DIR_UP   = 2'b10;
  localparam logic [1:0] DIR_LEFT = 2'b11;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EDGE, EMIT, DONE} state_t;
endpackage

// File: rtl/tb_symbol_decode.sv
// Priority decode of a one-hot direction symbol (DIAG > UP > LEFT) with
// correction of moves that would step off the matrix edge.
module tb_symbol_decode
  import tb_pkg::*;
(
  input  logic [2:0] i_symbol,
  input  logic       i_row_zero,
  input  logic       i_col_zero,
  output logic [1:0] o_dir,
  output logic       o_illegal
);
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    o_dir     = DIR_DIAG;
    o_illegal = 1'b0;
    if ((i_symbol & SYM_DIAG) != '0)      o_dir = DIR_DIAG;
    else if ((i_symbol & SYM_UP) != '0)   o_dir = DIR_UP;
    else if ((i_symbol & SYM_LEFT) != '0) o_dir = DIR_LEFT;
    else                                  o_illegal = 1'b1;

    // On row 0 only LEFT is possible, on column 0 only UP.
    if (o_dir != DIR_LEFT && i_row_zero)    o_dir = DIR_LEFT;
    else if (o_dir != DIR_UP && i_col_zero) o_dir = DIR_UP;
  end
endmodule

// File: rtl/traceback_walker.sv
// Traceback engine: walks the direction matrix from (len_i, len_j) back to
// (0,0), reading interior symbols from RAM and emitting one step per handshake.
module traceback_walker
  import tb_pkg::*;
#(
  parameter  int N      = 128,
  parameter  int M      = 128,
  parameter  int RD_LAT = 2,
  localparam int BI     = $clog2(N + 1),
  localparam int BJ     = $clog2(M + 1),
  localparam int SW     = $clog2(N + M + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [BI-1:0] len_i,
  input  logic [BJ-1:0] len_j,
  output logic          rd_en,
  output logic [BI-1:0] rd_i,
  output logic [BJ-1:0] rd_j,
  input  logic [2:0]    symbol,
  output logic          step_valid,
  input  logic          step_ready,
  output logic [1:0]    step_dir,
  output logic [BI-1:0] step_i,
  output logic [BJ-1:0] step_j,
  output logic [SW-1:0] steps,
  output logic          busy,
  output logic          done,
  output logic          err
);
  localparam int WW = $clog2(RD_LAT + 1);

  state_t          r_state;
  logic [BI-1:0]   r_i, r_rd_i, r_step_i;
  logic [BJ-1:0]   r_j, r_rd_j, r_step_j;
  logic [WW-1:0]   r_wait;
  logic [SW-1:0]   r_steps;
  logic [1:0]      r_step_dir;
  logic            r_rd_en, r_step_valid, r_busy, r_done, r_err;

  logic [2:0]      w_dec_sym;
  logic [1:0]      w_dir;
  logic            w_illegal, w_dec_i, w_dec_j, w_advance;
  logic [BI-1:0]   w_nxt_i;
  logic [BJ-1:0]   w_nxt_j;
  state_t          w_route;

  // EDGE cells feed a DIAG through the decoder; its edge correction picks UP or LEFT.
  assign w_dec_sym = (r_state == EDGE) ? SYM_DIAG : symbol;

  tb_symbol_decode u_decode (
    .i_symbol   (w_dec_sym),
    .i_row_zero (r_i == '0),
    .i_col_zero (r_j == '0),
    .o_dir      (w_dir),
    .o_illegal  (w_illegal)
  );

  assign w_advance = (r_state == IDLE && start) || (r_state == EMIT && step_ready);

  // Next coordinates: clamped launch cell in IDLE, post-step cell in EMIT.
  always_comb begin
    w_dec_i = (r_step_dir == DIR_DIAG) || (r_step_dir == DIR_UP);
    w_dec_j = (r_step_dir == DIR_DIAG) || (r_step_dir == DIR_LEFT);
    if (r_state == IDLE) begin
      w_nxt_i = (len_i > BI'(N)) ? BI'(N) : len_i;
      w_nxt_j = (len_j > BJ'(M)) ? BJ'(M) : len_j;
    end else begin
      w_nxt_i = r_i - BI'(w_dec_i);
      w_nxt_j = r_j - BJ'(w_dec_j);
    end
    if (w_nxt_i == '0 && w_nxt_j == '0)      w_route = DONE;
    else if (w_nxt_i == '0 || w_nxt_j == '0) w_route = EDGE;
    else                                     w_route = ISSUE;
  end

  // NOTE: sequential state uses non-blocking assignments only; later ones in the block win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_i          <= '0;
      r_j          <= '0;
      r_wait       <= '0;
      r_steps      <= '0;
      r_rd_en      <= 1'b0;
      r_rd_i       <= '0;
      r_rd_j       <= '0;
      r_step_valid <= 1'b0;
      r_step_dir   <= '0;
      r_step_i     <= '0;
      r_step_j     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_rd_en <= 1'b0;
      r_rd_i  <= '0;
      r_rd_j  <= '0;
      r_done  <= 1'b0;
      if (abort) begin
        r_state      <= IDLE;
        r_i          <= '0;
        r_j          <= '0;
        r_wait       <= '0;
        r_steps      <= '0;
        r_step_valid <= 1'b0;
        r_step_dir   <= '0;
        r_step_i     <= '0;
        r_step_j     <= '0;
        r_busy       <= 1'b0;
      end else if (w_advance) begin
        r_i     <= w_nxt_i;
        r_j     <= w_nxt_j;
        r_state <= w_route;
        r_busy  <= (w_route != DONE);
        r_done  <= (w_route == DONE);
        r_rd_en <= (w_route == ISSUE);
        r_rd_i  <= (w_route == ISSUE) ? w_nxt_i - BI'(1) : '0;
        r_rd_j  <= (w_route == ISSUE) ? w_nxt_j - BJ'(1) : '0;
        if (r_state == IDLE) begin
          r_steps <= '0;
          r_err   <= 1'b0;
        end else begin
          r_steps      <= r_steps + SW'(1);
          r_step_valid <= 1'b0;
          r_step_dir   <= '0;
          r_step_i     <= '0;
          r_step_j     <= '0;
        end
      end else begin
        unique case (r_state)
          ISSUE: begin
            r_state <= WAIT;
            r_wait  <= WW'(RD_LAT - 1);
          end
          WAIT, EDGE: begin
            if (r_state == WAIT && r_wait != '0) begin
              r_wait <= r_wait - WW'(1);
            end else if (w_illegal) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_step_valid <= 1'b1;
              r_step_dir   <= w_dir;
              r_step_i     <= r_i;
              r_step_j     <= r_j;
              r_state      <= EMIT;
            end
          end
          DONE:    r_state <= IDLE;
          default: ;
        endcase
      end
    end
  end

  assign rd_en      = r_rd_en;
  assign rd_i       = r_rd_i;
  assign rd_j       = r_rd_j;
  assign step_valid = r_step_valid;
  assign step_dir   = r_step_dir;
  assign step_i     = r_step_i;
  assign step_j     = r_step_j;
  assign steps      = r_steps;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
endmodule

// File: tb/tb_traceback_walker.sv
// Scoreboard bench for traceback_walker: directed walks on an 8x8 matrix,
// one instance at RD_LAT=2 and one at RD_LAT=3, checked by a decoupled monitor.
module tb_traceback_walker;
  import tb_pkg::*;

  localparam int N = 8, M = 8;
  localparam int BI = $clog2(N + 1), BJ = $clog2(M + 1), SW = $clog2(N + M + 1);

  typedef struct packed {
    logic [1:0]    dir;
    logic [BI-1:0] i;
    logic [BJ-1:0] j;
  } step_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, start3 = 1'b0, abort = 1'b0, sel = 1'b0;
  logic ready_ctl = 1'b1, rand_ready = 1'b0, rnd_bit = 1'b1;
  logic step_ready;
  logic [BI-1:0] len_i = '0;
  logic [BJ-1:0] len_j = '0;

  logic          a_rd_en, a_valid, a_busy, a_done, a_err, b_rd_en, b_valid, b_busy, b_done, b_err;
  logic [BI-1:0] a_rd_i, a_si, b_rd_i, b_si;
  logic [BJ-1:0] a_rd_j, a_sj, b_rd_j, b_sj;
  logic [1:0]    a_dir, b_dir;
  logic [SW-1:0] a_steps, b_steps;
  logic [2:0]    a_symbol, b_symbol;

  always #5 clk = ~clk;
  assign step_ready = rand_ready ? rnd_bit : ready_ctl;

  traceback_walker #(.N(N), .M(M), .RD_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len_i(len_i), .len_j(len_j),
    .rd_en(a_rd_en), .rd_i(a_rd_i), .rd_j(a_rd_j), .symbol(a_symbol),
    .step_valid(a_valid), .step_ready(step_ready), .step_dir(a_dir), .step_i(a_si), .step_j(a_sj),
    .steps(a_steps), .busy(a_busy), .done(a_done), .err(a_err));

  traceback_walker #(.N(N), .M(M), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort), .len_i(len_i), .len_j(len_j),
    .rd_en(b_rd_en), .rd_i(b_rd_i), .rd_j(b_rd_j), .symbol(b_symbol),
    .step_valid(b_valid), .step_ready(step_ready), .step_dir(b_dir), .step_i(b_si), .step_j(b_sj),
    .steps(b_steps), .busy(b_busy), .done(b_done), .err(b_err));

  // Observed instance
  logic          m_rd_en, m_valid, m_busy, m_done, m_err;
  logic [BI-1:0] m_rd_i, m_i;
  logic [BJ-1:0] m_rd_j, m_j;
  logic [1:0]    m_dir;
  logic [SW-1:0] m_steps;
  assign m_rd_en = sel ? b_rd_en : a_rd_en;
  assign m_rd_i  = sel ? b_rd_i  : a_rd_i;
  assign m_rd_j  = sel ? b_rd_j  : a_rd_j;
  assign m_valid = sel ? b_valid : a_valid;
  assign m_dir   = sel ? b_dir   : a_dir;
  assign m_i     = sel ? b_si    : a_si;
  assign m_j     = sel ? b_sj    : a_sj;
  assign m_steps = sel ? b_steps : a_steps;
  assign m_busy  = sel ? b_busy  : a_busy;
  assign m_done  = sel ? b_done  : a_done;
  assign m_err   = sel ? b_err   : a_err;

  // Direction-matrix RAM with fixed read latency per instance; 000 between reads.
  logic [2:0] mem [0:(1<<BI)-1][0:(1<<BJ)-1];
  logic [2:0] pipe2 [1:2];
  logic [2:0] pipe3 [1:3];
  always @(posedge clk) begin
    pipe2[1] <= a_rd_en ? mem[a_rd_i][a_rd_j] : 3'b000;
    pipe2[2] <= pipe2[1];
    pipe3[1] <= b_rd_en ? mem[b_rd_i][b_rd_j] : 3'b000;
    pipe3[2] <= pipe3[1];
    pipe3[3] <= pipe3[2];
  end
  assign a_symbol = pipe2[2];
  assign b_symbol = pipe3[3];

  always begin
    @(posedge clk);
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  int total = 0, bad = 0, cyc = 0, last_hs = -10, done_cnt = 0;
  step_t exp_q[$];
  logic [BI+BJ-1:0] rd_q[$];
  int rd_cyc_q[$], hs_cyc_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, {4'd0, m_busy, m_valid, m_rd_en, m_done, m_err, m_steps, m_dir,
                 m_i, m_j, m_rd_i, m_rd_j}, 32'd0);
  endtask

  function automatic step_t mk(input logic [1:0] d, input int i, input int j);
    return {d, BI'(i), BJ'(j)};
  endfunction

  function automatic logic [BI+BJ-1:0] ra(input int i, input int j);
    return {BI'(i), BJ'(j)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected reads and steps, checks hold-while-stalled and done latency.
  step_t held;
  logic  hold_pend = 1'b0, prev_abort = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend  = 1'b0;
      prev_abort = 1'b0;
    end else begin
      if (hold_pend && !prev_abort) begin
        check("hold_valid", m_valid, 1);
        check("hold_step", {m_dir, m_i, m_j}, held);
      end
      hold_pend = 1'b0;
      if (m_rd_en) begin
        rd_cyc_q.push_back(cyc);
        if (rd_q.size() == 0) check("rd_unexpected", m_rd_en, 0);
        else check("rd_addr", {m_rd_i, m_rd_j}, rd_q.pop_front());
      end else begin
        check("rd_idle_addr", {m_rd_i, m_rd_j}, 0);
      end
      if (m_valid && step_ready) begin
        hs_cyc_q.push_back(cyc);
        last_hs = cyc;
        if (exp_q.size() == 0) check("step_unexpected", m_valid, 0);
        else check("step", {m_dir, m_i, m_j}, exp_q.pop_front());
      end else if (m_valid) begin
        held      = {m_dir, m_i, m_j};
        hold_pend = 1'b1;
      end
      if (m_done) begin
        done_cnt++;
        check("done_latency", cyc - last_hs, 1);
      end
      prev_abort = abort;
    end
  end

  task automatic fill(input logic [2:0] s);
    for (int i = 0; i < (1 << BI); i++)
      for (int j = 0; j < (1 << BJ); j++) mem[i][j] = s;
  endtask

  task automatic go(input int li, input int lj, input bit use3);
    rd_cyc_q.delete();
    hs_cyc_q.delete();
    @(posedge clk);
    #1;
    len_i = BI'(li);
    len_j = BJ'(lj);
    if (use3) start3 = 1'b1;
    else start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!m_busy) break;
    end
    check("walk_timeout", m_busy, 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    fill(3'b000);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset_state");

    // 3x3 all DIAG, ready high
    fill(SYM_DIAG);
    exp_q.push_back(mk(DIR_DIAG, 3, 3));
    exp_q.push_back(mk(DIR_DIAG, 2, 2));
    exp_q.push_back(mk(DIR_DIAG, 1, 1));
    rd_q.push_back(ra(2, 2)); rd_q.push_back(ra(1, 1)); rd_q.push_back(ra(0, 0));
    d0 = done_cnt;
    go(3, 3, 0);
    wait_idle(100);
    check("t1_rd_count", rd_cyc_q.size(), 3);
    if (rd_cyc_q.size() >= 3) begin
      check("t1_rd_gap_a", rd_cyc_q[1] - rd_cyc_q[0], 4);
      check("t1_rd_gap_b", rd_cyc_q[2] - rd_cyc_q[1], 4);
    end
    check("t1_steps", m_steps, 3);
    check("t1_done", done_cnt - d0, 1);
    check("t1_queue", exp_q.size(), 0);

    // 2x0 pure edge walk
    exp_q.push_back(mk(DIR_UP, 2, 0));
    exp_q.push_back(mk(DIR_UP, 1, 0));
    d0 = done_cnt;
    go(2, 0, 0);
    wait_idle(100);
    check("t2_rd_count", rd_cyc_q.size(), 0);
    check("t2_hs_count", hs_cyc_q.size(), 2);
    if (hs_cyc_q.size() >= 2) check("t2_hs_gap", hs_cyc_q[1] - hs_cyc_q[0], 2);
    check("t2_steps", m_steps, 2);
    check("t2_done", done_cnt - d0, 1);

    // 4x5 mixed path with random back-pressure
    fill(3'b000);
    mem[3][4] = SYM_UP; mem[2][4] = SYM_LEFT; mem[2][3] = SYM_DIAG;
    mem[1][2] = SYM_DIAG; mem[0][1] = SYM_DIAG;
    rd_q.push_back(ra(3, 4)); rd_q.push_back(ra(2, 4)); rd_q.push_back(ra(2, 3));
    rd_q.push_back(ra(1, 2)); rd_q.push_back(ra(0, 1));
    exp_q.push_back(mk(DIR_UP, 4, 5));
    exp_q.push_back(mk(DIR_LEFT, 3, 5));
    exp_q.push_back(mk(DIR_DIAG, 3, 4));
    exp_q.push_back(mk(DIR_DIAG, 2, 3));
    exp_q.push_back(mk(DIR_DIAG, 1, 2));
    exp_q.push_back(mk(DIR_LEFT, 0, 1));
    d0 = done_cnt;
    rand_ready = 1'b1;
    go(4, 5, 0);
    wait_idle(400);
    rand_ready = 1'b0;
    check("t3_steps", m_steps, 6);
    check("t3_done", done_cnt - d0, 1);
    check("t3_err", m_err, 0);
    check("t3_queue", exp_q.size(), 0);

    // Illegal symbol on second read, then a fresh start clears err
    fill(SYM_DIAG);
    mem[1][1] = 3'b000;
    rd_q.push_back(ra(2, 2)); rd_q.push_back(ra(1, 1));
    exp_q.push_back(mk(DIR_DIAG, 3, 3));
    d0 = done_cnt;
    go(3, 3, 0);
    wait_idle(100);
    check("t4_err_set", m_err, 1);
    check("t4_no_done", done_cnt - d0, 0);
    check("t4_idle", {m_valid, m_busy}, 0);
    check("t4_steps", m_steps, 1);
    exp_q.push_back(mk(DIR_LEFT, 0, 1));
    go(0, 1, 0);
    check("t4_err_cleared", m_err, 0);
    wait_idle(100);
    check("t4_done", done_cnt - d0, 1);

    // Multi-hot symbol decodes as UP, then row-0 edge forces LEFT
    fill(3'b000);
    mem[0][1] = 3'b110;
    rd_q.push_back(ra(0, 1));
    exp_q.push_back(mk(DIR_UP, 1, 2));
    exp_q.push_back(mk(DIR_LEFT, 0, 2));
    exp_q.push_back(mk(DIR_LEFT, 0, 1));
    d0 = done_cnt;
    go(1, 2, 0);
    wait_idle(100);
    check("t5_err", m_err, 0);
    check("t5_steps", m_steps, 3);
    check("t5_done", done_cnt - d0, 1);

    // Reset pulsed during WAIT
    fill(SYM_DIAG);
    rd_q.push_back(ra(2, 2));
    go(3, 3, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 check_zero("t6_reset_async");
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    rd_q.delete();
    @(negedge clk);
    check_zero("t6_after_reset");

    // Abort while a step is stalled in EMIT
    ready_ctl = 1'b0;
    d0 = done_cnt;
    go(2, 0, 0);
    for (int n = 0; n < 20 && !m_valid; n++) @(negedge clk);
    check("t6_emit_reached", m_valid, 1);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check_zero("t6_abort_now");
    @(negedge clk);
    check_zero("t6_abort_next");
    check("t6_abort_no_done", done_cnt - d0, 0);
    ready_ctl = 1'b1;

    // Rerun on the RD_LAT=3 instance
    sel = 1'b1;
    @(negedge clk);
    exp_q.push_back(mk(DIR_DIAG, 3, 3));
    exp_q.push_back(mk(DIR_DIAG, 2, 2));
    exp_q.push_back(mk(DIR_DIAG, 1, 1));
    rd_q.push_back(ra(2, 2)); rd_q.push_back(ra(1, 1)); rd_q.push_back(ra(0, 0));
    d0 = done_cnt;
    go(3, 3, 1);
    wait_idle(100);
    check("t7_rd_count", rd_cyc_q.size(), 3);
    if (rd_cyc_q.size() >= 2) check("t7_rd_gap", rd_cyc_q[1] - rd_cyc_q[0], 5);
    check("t7_steps", m_steps, 3);
    check("t7_done", done_cnt - d0, 1);
    check("t7_queue", exp_q.size() + rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/traceback_walker.md
# traceback_walker

Parametrised traceback engine for the Needleman-Wunsch datapath. Walks the direction matrix from a run-time cell (len_i, len_j) back to (0,0), fetching each direction symbol from the traceback RAM with a configurable read latency. Emits one path step per handshake to the alignment-output stage. Replaces the fixed-size, fixed-cadence traceback counter with:
- rectangular and variable-length matrices
- back-pressure
- RAM-free edge steps
- error and abort handling

## Interface
Parameters:
- N, 128, maximum rows (sequence A length), N ≥ 2
- M, 128, maximum columns (sequence B length), M ≥ 2
- RD_LAT, 2, traceback RAM read latency in cycles, ≥ 1
- BI = $clog2(N+1), BJ = $clog2(M+1), derived coordinate widths
- SW = $clog2(N+M+1), derived step-count width

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  rising-edge clock
  - rst_n  in  1  asynchronous active-low reset
- Control:
  - start  in  1  launch a walk; sampled only in IDLE
  - abort  in  1  synchronous abort, any state → IDLE
  - len_i  in  BI  start row, ≤ N, latched on start
  - len_j  in  BJ  start column, ≤ M, latched on start
- RAM read side:
  - rd_en  out  1  one-cycle RAM read strobe
  - rd_i  out  BI  RAM row address = i−1; 0 when rd_en=0
  - rd_j  out  BJ  RAM column address = j−1; 0 when rd_en=0
  - symbol  in  3  RAM data, valid exactly RD_LAT cycles after rd_en
- Step stream:
  - step_valid  out  1  step available
  - step_ready  in  1  downstream accepts
  - step_dir  out  2  01 DIAG, 10 UP, 11 LEFT
  - step_i, step_j  out  BI/BJ  coordinates of the cell the step leaves
- Status:
  - steps  out  SW  accepted steps since start
  - busy  out  1  walk in progress
  - done  out  1  one-cycle pulse on reaching (0,0)
  - err  out  1  sticky illegal-symbol flag, cleared on start

## Operation
- Symbol encoding is one-hot: DIAG=3'b001, UP=3'b010, LEFT=3'b100.
- Multi-hot symbols decode with priority DIAG > UP > LEFT.
- Symbol 3'b000 is illegal.

States and transitions:
- IDLE: busy=0.
  - On start, latch i=len_i, j=len_j; clear steps and err.
  - (0,0) → DONE.
  - Either coordinate zero → EDGE; otherwise → ISSUE.
- ISSUE: rd_en=1 with rd_i=i−1, rd_j=j−1 for exactly one cycle → WAIT. Load wait counter to RD_LAT−1.
- WAIT: count down. At zero, sample symbol.
  - Legal symbol: register the decoded dir → EMIT.
  - Illegal symbol: set err → IDLE, with no done pulse.
- EDGE: no RAM access.
  - i==0 forces LEFT.
  - j==0 forces UP.
  - → EMIT.
- EMIT: step_valid=1. step_dir, step_i, step_j are held stable until step_ready.
  - On handshake: DIAG i−1,j−1; UP i−1; LEFT j−1; steps+1.
  - New (0,0) → DONE.
  - Otherwise → ISSUE or EDGE by the IDLE rule.
- DONE: done=1 for one cycle, busy=0 → IDLE.

Other rules:
- A RAM symbol that would underflow is corrected at the edge: UP at i==0 is treated as LEFT, LEFT at j==0 as UP. err is not set.
- start is ignored while busy.
- abort has priority over every transition. It suppresses done and leaves err unchanged.
- len_i > N or len_j > M is clamped to N or M at latch time.

## Timing
- Reset values: state IDLE; all outputs 0; i, j, counters 0.
- Interior step with step_ready held high: ISSUE + RD_LAT WAIT cycles + 1 EMIT = RD_LAT+2 cycles. That is 4 cycles at the default.
- Edge step: 2 cycles (EDGE, EMIT).
- step_valid is never deasserted without a handshake, except on abort or reset.
- done is asserted on the cycle after the final handshake.
- rd_en is never asserted in EDGE, EMIT, DONE or IDLE.
- Reset mid-walk returns everything to reset values immediately. A symbol still in flight is ignored.

## Structure
- Package tb_pkg holds:
  - symbol constants DIAG/UP/LEFT
  - 2-bit step_dir codes
  - the state enum (IDLE, ISSUE, WAIT, EDGE, EMIT, DONE)
- Sub-module tb_symbol_decode: combinational priority decode of symbol, i and j into dir plus an illegal flag. Shared with the score-path checker.

## Test plan
- N=M=8, len 3×3, RAM all DIAG, ready=1 → three DIAG steps (3,3),(2,2),(1,1); rd_en cycles 4 apart; done 1 cycle after the 3rd handshake; steps=3.
- len 2×0 → two UP steps, no rd_en ever asserted, 2 cycles per step, done pulses.
- len 4×5, symbols UP,LEFT,DIAG then edge → path correct; step_ready randomly low holds step_* stable; final steps equals path length.
- Symbol 3'b000 at the second read → err=1, IDLE, no done; a new start clears err.
- Multi-hot 3'b110 → UP; symbol UP at i==0 → LEFT step, err=0.
- rst_n pulsed low during WAIT, and abort during EMIT → all outputs 0, IDLE next cycle, RD_LAT=3 rerun correct.
